// File: rtl/ps2_host_tx_pkg.sv
// Shared constants, state encoding and parity helper for the PS/2 host command path.
package ps2_host_tx_pkg;

  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACKBIT,
    S_WAITRSP
  } ps2_tx_state_e;

  // Parity bit that makes {parity, data} contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_clk_filter.sv
// 8-tap glitch filter on the PS/2 clock pin with a falling-edge strobe; shared with the keyboard decoder.
module ps2_clk_filter (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ce,
  input  logic i_ps2_clk,
  output logic o_fall
);

  logic [7:0] r_shift;
  logic       r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= 8'hFF;
      r_level <= 1'b1;
    end else if (i_ce) begin
      r_shift <= {r_shift[6:0], i_ps2_clk};
      if (r_shift == 8'hFF)      r_level <= 1'b1;
      else if (r_shift == 8'h00) r_level <= 1'b0;
    end
  end

  // Strobe on the very tick the filtered level drops.
  assign o_fall = i_ce & r_level & (r_shift == 8'h00);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, clock out one byte, then await the reply.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1600,
  parameter int TIMEOUT_CYCLES = 32000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic [1:0] i_ps2,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  input  logic       i_req,
  input  logic [7:0] i_cmd,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_rsp,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_block
);
  import ps2_host_tx_pkg::*;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  ps2_tx_state_e r_state, w_state;
  logic [15:0]   r_timer, w_timer;
  logic [3:0]    r_idx, w_idx;
  logic [8:0]    r_sr, w_sr;
  logic [7:0]    r_cmd, w_cmd, r_rsp, w_rsp;
  logic [RW-1:0] r_retry, w_retry;
  logic r_clk_oe, w_clk_oe, r_dat_oe, w_dat_oe, r_busy, w_busy;
  logic r_rx_block, w_rx_block, r_done, w_done, r_err, w_err;
  logic r_dat, w_fall, w_expired;

  ps2_clk_filter u_clk_filter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ce      (i_ce),
    .i_ps2_clk (i_ps2[0]),
    .o_fall    (w_fall)
  );

  assign w_expired = (r_timer == 16'd0);

  always_comb begin
    w_state    = r_state;
    w_timer    = w_expired ? 16'd0 : r_timer - 16'd1;
    w_idx      = r_idx;
    w_sr       = r_sr;
    w_cmd      = r_cmd;
    w_rsp      = r_rsp;
    w_retry    = r_retry;
    w_clk_oe   = r_clk_oe;
    w_dat_oe   = r_dat_oe;
    w_busy     = r_busy;
    w_rx_block = r_rx_block;
    w_done     = 1'b0;
    w_err      = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_req) begin
        w_cmd      = i_cmd;
        w_busy     = 1'b1;
        w_rx_block = 1'b1;
        w_clk_oe   = 1'b1;
        w_timer    = 16'(INHIBIT_CYCLES);
        w_state    = S_INHIBIT;
      end
      S_INHIBIT: if (w_expired) begin
        w_sr     = {odd_parity(r_cmd), r_cmd};
        w_dat_oe = 1'b1;
        w_timer  = 16'(TIMEOUT_CYCLES - 1);
        w_state  = S_RTS;
      end
      // RTS and SEND share one timeout window, measured from RTS entry.
      S_RTS: begin
        w_clk_oe = 1'b0;
        w_idx    = 4'd0;
        w_state  = S_SEND;
      end
      S_SEND: begin
        if (w_fall) begin
          if (r_idx == 4'd9) begin
            w_dat_oe = 1'b0;
            w_timer  = 16'(TIMEOUT_CYCLES - 1);
            w_state  = S_ACKBIT;
          end else begin
            w_dat_oe = ~r_sr[0];
            w_sr     = {1'b0, r_sr[8:1]};
            w_idx    = r_idx + 4'd1;
          end
        end else if (w_expired) w_err = 1'b1;
      end
      S_ACKBIT: begin
        if (w_fall) begin
          if (!r_dat) begin
            w_rx_block = 1'b0;
            w_timer    = 16'(TIMEOUT_CYCLES - 1);
            w_state    = S_WAITRSP;
          end else w_err = 1'b1;
        end else if (w_expired) w_err = 1'b1;
      end
      S_WAITRSP: begin
        if (i_rx_valid) begin
          w_rsp = i_rx_data;
          if (i_rx_data == PS2_RSP_ACK || i_rx_data == PS2_RSP_BAT_OK) w_done = 1'b1;
          else if (i_rx_data == PS2_RSP_RESEND && r_retry < RW'(MAX_RETRY)) begin
            w_retry    = r_retry + 1'b1;
            w_clk_oe   = 1'b1;
            w_rx_block = 1'b1;
            w_timer    = 16'(INHIBIT_CYCLES);
            w_state    = S_INHIBIT;
          end else w_err = 1'b1;
        end else if (w_expired) w_err = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_done || w_err) begin
      w_state    = S_IDLE;
      w_busy     = 1'b0;
      w_rx_block = 1'b0;
      w_retry    = '0;
      w_clk_oe   = 1'b0;
      w_dat_oe   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= 16'd0;
      r_idx      <= 4'd0;
      r_sr       <= 9'd0;
      r_cmd      <= 8'd0;
      r_rsp      <= 8'd0;
      r_retry    <= '0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_block <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= 1'b1;
    end else if (i_ce) begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_idx      <= w_idx;
      r_sr       <= w_sr;
      r_cmd      <= w_cmd;
      r_rsp      <= w_rsp;
      r_retry    <= w_retry;
      r_clk_oe   <= w_clk_oe;
      r_dat_oe   <= w_dat_oe;
      r_busy     <= w_busy;
      r_rx_block <= w_rx_block;
      r_done     <= w_done;
      r_err      <= w_err;
      r_dat      <= i_ps2[1];
    end
  end

  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_dat_oe = r_dat_oe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_rsp        = r_rsp;
  assign o_rx_block   = r_rx_block;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and answers with reply bytes.
module tb_ps2_host_tx;
  localparam int IC   = 20;
  localparam int TO   = 600;
  localparam int MR   = 3;
  localparam int HALF = 16;

  logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b0, req = 1'b0, rx_valid = 1'b0;
  logic [7:0] cmd = 8'h00, rx_data = 8'h00;
  logic       clk_oe, dat_oe, busy, done, err, rx_block;
  logic [7:0] rsp;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic [1:0] ps2;

  // Open-drain wired-AND of host and device pulls.
  assign ps2[0] = ~(clk_oe | dev_clk_low);
  assign ps2[1] = ~(dat_oe | dev_dat_low);

  int   n_checks = 0, n_errors = 0;
  int   n_done = 0, n_err = 0, wait_cnt = 0;
  logic done_q = 1'b0, err_q = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_ps2(ps2),
    .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe),
    .i_req(req), .i_cmd(cmd), .o_busy(busy), .o_done(done), .o_err(err), .o_rsp(rsp),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_block(rx_block)
  );

  always #5 clk = ~clk;
  initial forever @(negedge clk) ce = ~ce;

  always @(negedge clk) begin
    if (done && !done_q) n_done <= n_done + 1;
    if (err && !err_q) n_err <= n_err + 1;
    if (busy && !rx_block) wait_cnt <= wait_cnt + 1;
    done_q <= done;
    err_q  <= err;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    do @(posedge clk); while (!ce);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reference outcome from the reply rules: frames sent, success flag, final rsp.
  function automatic void model(input logic [7:0] rep[8], input int nrep,
                                output int frames, output bit ok, output logic [7:0] last);
    int resends = 0;
    frames = 0; ok = 1'b0; last = 8'h00;
    for (int k = 0; k < nrep; k++) begin
      frames++;
      last = rep[k];
      if (rep[k] == 8'hFA || rep[k] == 8'hAA) begin ok = 1'b1; return; end
      if (rep[k] != 8'hFE || resends == MR) return;
      resends++;
    end
  endfunction

  task automatic start_req(input logic [7:0] c);
    int n;
    tick();
    req = 1'b1; cmd = c;
    tick();
    req = 1'b0; cmd = 8'($urandom);
    n_checks++;
    if (busy !== 1'b1 || clk_oe !== 1'b1) begin
      n_errors++; $display("FAIL accept busy=%b clk_oe=%b want 1 1", busy, clk_oe);
    end
    n = 0;
    while (dat_oe !== 1'b1 && n < 4 * IC) begin tick(); n++; end
    n_checks++;
    if (n != IC + 1) begin n_errors++; $display("FAIL rts_latency got %0d want %0d", n, IC + 1); end
    n_checks++;
    if (clk_oe !== 1'b1) begin n_errors++; $display("FAIL rts_overlap clk_oe=%b want 1", clk_oe); end
  endtask

  // Device side: wait for request-to-send, clock 10 bits in, then clock the ack bit.
  task automatic device_frame(input bit ack_low, input bit poke, output logic [10:0] fr);
    int n = 0;
    fr = '1;
    while (!(ps2[0] === 1'b1 && ps2[1] === 1'b0) && n < 4 * TO) begin tick(); n++; end
    fr[0] = ps2[1];
    ticks(HALF);
    for (int i = 1; i <= 10; i++) begin
      if (poke && i == 5) begin req = 1'b1; cmd = 8'($urandom); tick(); req = 1'b0; end
      dev_clk_low = 1'b1; ticks(HALF);
      fr[i] = ps2[1];
      dev_clk_low = 1'b0; ticks(HALF);
    end
    dev_dat_low = ack_low;
    dev_clk_low = 1'b1; ticks(HALF);
    dev_clk_low = 1'b0; ticks(HALF);
    dev_dat_low = 1'b0;
  endtask

  task automatic send_reply(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 4 * TO) begin tick(); n++; end
    ticks(2);
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [7:0] rep[8], input int nrep,
                         input string tag, output logic [10:0] fr0);
    int frames, d0, e0;
    bit ok;
    logic [7:0] last;
    logic [10:0] fr, exp_fr;
    model(rep, nrep, frames, ok, last);
    exp_fr = {1'b1, ~^c, c, 1'b0};
    d0 = n_done; e0 = n_err; fr0 = '0;
    start_req(c);
    for (int k = 0; k < frames; k++) begin
      device_frame(1'b1, 1'b0, fr);
      if (k == 0) fr0 = fr;
      n_checks++;
      if (fr !== exp_fr) begin n_errors++; $display("FAIL %s frame%0d got %b want %b", tag, k, fr, exp_fr); end
      n_checks++;
      if (busy !== 1'b1 || rx_block !== 1'b0) begin
        n_errors++; $display("FAIL %s waitrsp%0d busy=%b rx_block=%b want 1 0", tag, k, busy, rx_block);
      end
      send_reply(rep[k]);
    end
    wait_idle();
    n_checks++;
    if ((n_done - d0) != (ok ? 1 : 0) || (n_err - e0) != (ok ? 0 : 1)) begin
      n_errors++; $display("FAIL %s outcome done=%0d err=%0d want ok=%0d", tag, n_done - d0, n_err - e0, ok);
    end
    n_checks++;
    if (rsp !== last) begin n_errors++; $display("FAIL %s rsp got %h want %h", tag, rsp, last); end
    n_checks++;
    if ({busy, rx_block, clk_oe, dat_oe} !== 4'b0000) begin
      n_errors++; $display("FAIL %s release got %b want 0000", tag, {busy, rx_block, clk_oe, dat_oe});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({clk_oe, dat_oe, busy, done, err, rx_block, rsp} !== 14'd0) begin
      n_errors++; $display("FAIL reset_vals got %b %h want all 0", {clk_oe, dat_oe, busy, done, err, rx_block}, rsp);
    end
    rst_n = 1'b1;
    ticks(3);
    n_checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      n_errors++; $display("FAIL idle_after_reset got %b want 000", {clk_oe, dat_oe, busy});
    end
  endtask

  task automatic test_leds();
    logic [7:0] rep[8];
    logic [10:0] fr0, want;
    rep = '{default: 8'h00};
    rep[0] = 8'hFA;
    run_txn(8'hED, rep, 1, "leds", fr0);
    want = 11'b1_1_11101101_0;
    n_checks++;
    if (fr0 !== want) begin n_errors++; $display("FAIL leds_bits got %b want %b", fr0, want); end
  endtask

  task automatic test_retry2();
    logic [7:0] rep[8];
    logic [10:0] fr0;
    rep = '{default: 8'h00};
    rep[0] = 8'hFE; rep[1] = 8'hFE; rep[2] = 8'hFA;
    run_txn(8'hFF, rep, 3, "retry2", fr0);
  endtask

  task automatic test_retry_exhaust();
    logic [7:0] rep[8];
    logic [10:0] fr0;
    rep = '{default: 8'hFE};
    run_txn(8'($urandom), rep, 4, "exhaust", fr0);
  endtask

  task automatic test_timeout();
    int m = 0, e0;
    e0 = n_err;
    start_req(8'($urandom));
    do begin tick(); m++; end while (err !== 1'b1 && m < 2 * TO);
    n_checks++;
    if (m != TO) begin n_errors++; $display("FAIL timeout_ticks got %0d want %0d", m, TO); end
    n_checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      n_errors++; $display("FAIL timeout_release got %b want 000", {clk_oe, dat_oe, busy});
    end
    ticks(2);
    n_checks++;
    if (n_err - e0 != 1) begin n_errors++; $display("FAIL timeout_err got %0d want 1", n_err - e0); end
  endtask

  task automatic test_ack_nak();
    int d0, e0, w0;
    logic [7:0] c;
    logic [10:0] fr;
    c = 8'($urandom);
    d0 = n_done; e0 = n_err; w0 = wait_cnt;
    start_req(c);
    device_frame(1'b0, 1'b1, fr);
    n_checks++;
    if (fr !== {1'b1, ~^c, c, 1'b0}) begin n_errors++; $display("FAIL nak_frame got %b want %b", fr, {1'b1, ~^c, c, 1'b0}); end
    wait_idle();
    n_checks++;
    if (n_err - e0 != 1 || n_done - d0 != 0) begin
      n_errors++; $display("FAIL nak_outcome err=%0d done=%0d want 1 0", n_err - e0, n_done - d0);
    end
    n_checks++;
    if (wait_cnt != w0) begin n_errors++; $display("FAIL nak_waitrsp got %0d cycles want 0", wait_cnt - w0); end
    ticks(40);
    n_checks++;
    if ({busy, clk_oe, dat_oe} !== 3'b000) begin
      n_errors++; $display("FAIL req_ignored got %b want 000", {busy, clk_oe, dat_oe});
    end
  endtask

  task automatic test_random();
    logic [7:0] rep[8];
    logic [10:0] fr0;
    int nfe;
    for (int t = 0; t < 5; t++) begin
      rep = '{default: 8'h00};
      nfe = $urandom_range(0, 4);
      for (int k = 0; k < nfe; k++) rep[k] = 8'hFE;
      case ($urandom_range(0, 2))
        0: rep[nfe] = 8'hFA;
        1: rep[nfe] = 8'hAA;
        default: begin
          rep[nfe] = 8'($urandom);
          while (rep[nfe] == 8'hFA || rep[nfe] == 8'hAA || rep[nfe] == 8'hFE) rep[nfe] = 8'($urandom);
        end
      endcase
      run_txn(8'($urandom), rep, nfe + 1, "random", fr0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rep[8];
    logic [10:0] fr0;
    int n = 0;
    start_req(8'($urandom));
    while (ps2[0] !== 1'b1 && n < 100) begin tick(); n++; end
    ticks(HALF);
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1; ticks(HALF);
      dev_clk_low = 1'b0; ticks(HALF);
    end
    dev_clk_low = 1'b1;
    ticks(4);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy got %b want 1", busy); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clk_oe, dat_oe, busy, rx_block} !== 4'b0000) begin
      n_errors++; $display("FAIL async_reset got %b want 0000", {clk_oe, dat_oe, busy, rx_block});
    end
    dev_clk_low = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    rep = '{default: 8'h00};
    rep[0] = 8'hFA;
    run_txn(8'($urandom), rep, 1, "post_reset", fr0);
  endtask

  initial begin
    test_reset();
    test_leds();
    test_retry2();
    test_retry_exhaust();
    test_timeout();
    test_ack_nak();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
